// File: rtl/fb_porta_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_porta_arbiter_if
// Description : Bundles every port-A related signal of the framebuffer
//               arbiter: host write/read request streams, read return,
//               clear-engine control and the memory port-A pins.
//               slave  - seen by the arbiter
//               master - seen by the host / memory side
// Revision    : 1.0  initial release
// ============================================================================
interface fb_porta_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  // Host write stream
  logic                  WrReqValid;
  logic                  WrReqReady;
  logic [ADDR_WIDTH-1:0] WrReqAddr;
  logic [DATA_WIDTH-1:0] WrReqData;
  // Host read stream
  logic                  RdReqValid;
  logic                  RdReqReady;
  logic [ADDR_WIDTH-1:0] RdReqAddr;
  logic                  RdDataValid;
  logic [DATA_WIDTH-1:0] RdData;
  // Clear engine control
  logic                  ClearStart;
  logic [DATA_WIDTH-1:0] ClearValue;
  logic                  ClearBusy;
  logic                  ClearDone;
  // Memory port A
  logic [ADDR_WIDTH-1:0] MemAddressA;
  logic [DATA_WIDTH-1:0] MemDataInA;
  logic                  MemWrA;
  logic                  MemClockEnA;
  logic [DATA_WIDTH-1:0] MemQA;

  modport slave (
    input  WrReqValid, WrReqAddr, WrReqData,
    input  RdReqValid, RdReqAddr,
    input  ClearStart, ClearValue,
    input  MemQA,
    output WrReqReady, RdReqReady, RdDataValid, RdData,
    output ClearBusy, ClearDone,
    output MemAddressA, MemDataInA, MemWrA, MemClockEnA
  );

  modport master (
    output WrReqValid, WrReqAddr, WrReqData,
    output RdReqValid, RdReqAddr,
    output ClearStart, ClearValue,
    output MemQA,
    input  WrReqReady, RdReqReady, RdDataValid, RdData,
    input  ClearBusy, ClearDone,
    input  MemAddressA, MemDataInA, MemWrA, MemClockEnA
  );
endinterface
`default_nettype wire

// File: rtl/fb_porta_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_porta_arbiter
// Description : Owns port A of the 4096x8 framebuffer memory. Arbitrates
//               between a host write stream, a host read stream and an
//               internal clear engine; at most one memory command per clock,
//               read data returned RD_LATENCY+1 clocks after the handshake.
// Ports       : Clock   - system clock (also memory ClockA)
//               ResetN  - synchronous active-low reset
//               bus     - fb_porta_arbiter_if.slave: host request/return,
//                         clear control and memory port-A signals
// Revision    : 1.0  initial release
// ============================================================================
module fb_porta_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  wire logic             Clock,
  input  wire logic             ResetN,
  fb_porta_arbiter_if.slave     bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_last_rd;     // 1: read was granted last
  logic [ADDR_WIDTH:0]     r_sweep;       // extra MSB flags terminal count
  logic [DATA_WIDTH-1:0]   r_clr_val;
  logic [RD_LATENCY:0]     r_rd_pipe;     // read tag shift register
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_din;
  logic                    r_mem_wr;
  logic                    r_mem_cen;
  logic                    r_rd_valid;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_host_ok;
  logic                    w_wr_hs;
  logic                    w_rd_hs;

  // Host traffic is only granted in IDLE and never in a cycle where a clear
  // is being requested, so the clear always wins a simultaneous contest.
  assign w_host_ok = ResetN && (r_state == S_IDLE) && !bus.ClearStart;

  // On a tie the class not granted last time wins.
  assign w_wr_hs = w_host_ok && bus.WrReqValid && (!bus.RdReqValid ||  r_last_rd);
  assign w_rd_hs = w_host_ok && bus.RdReqValid && (!bus.WrReqValid || !r_last_rd);

  assign bus.WrReqReady  = w_wr_hs;
  assign bus.RdReqReady  = w_rd_hs;
  assign bus.RdDataValid = r_rd_valid;
  assign bus.RdData      = r_rd_data;
  assign bus.ClearBusy   = r_busy;
  assign bus.ClearDone   = r_done;
  assign bus.MemAddressA = r_mem_addr;
  assign bus.MemDataInA  = r_mem_din;
  assign bus.MemWrA      = r_mem_wr;
  assign bus.MemClockEnA = r_mem_cen;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state    <= S_IDLE;
      r_last_rd  <= 1'b1;
      r_sweep    <= '0;
      r_clr_val  <= '0;
      r_rd_pipe  <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_cen  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_cen <= 1'b1;
      r_mem_wr  <= 1'b0;
      r_done    <= 1'b0;

      // Read return path runs in every state so reads accepted before a
      // clear still drain with their pre-clear data.
      r_rd_pipe  <= {r_rd_pipe[RD_LATENCY-1:0], w_rd_hs};
      r_rd_valid <= r_rd_pipe[RD_LATENCY];
      if (r_rd_pipe[RD_LATENCY]) begin
        r_rd_data <= bus.MemQA;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.ClearStart) begin
            r_state   <= S_CLEAR;
            r_busy    <= 1'b1;
            r_sweep   <= '0;
            r_clr_val <= bus.ClearValue;
          end else if (w_wr_hs) begin
            r_mem_addr <= bus.WrReqAddr;
            r_mem_din  <= bus.WrReqData;
            r_mem_wr   <= 1'b1;
            r_last_rd  <= 1'b0;
          end else if (w_rd_hs) begin
            r_mem_addr <= bus.RdReqAddr;
            r_last_rd  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_sweep[ADDR_WIDTH]) begin
            // Every location has been written.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_mem_addr <= r_sweep[ADDR_WIDTH-1:0];
            r_mem_din  <= r_clr_val;
            r_mem_wr   <= 1'b1;
            r_sweep    <= r_sweep + {{ADDR_WIDTH{1'b0}}, 1'b1};
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
